gpr_file_sb: RTL
================

# gpr_file_sb

Parametrised general-purpose register file with an integrated busy-bit scoreboard; the next-generation replacement for the fixed 4×16-bit file in the CPU datapath. Provides two combinational read ports with optional write-through bypass, one synchronous write port, and per-register pending-write tracking. The decode stage uses it to detect RAW hazards and stall. Sits between decode (reads, issue) and writeback (writes).

## Interface
Parameters:
- WORD_SIZE, 16, data width in bits
- NUM_REGS, 4, register count; power of two, ≥2
- ADDR_W, $clog2(NUM_REGS), derived; not overridden
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- ZERO_R0, 0, 1 = register 0 hardwired to zero and never busy

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- rs1_addr, rs2_addr  in  ADDR_W  read addresses
- rs1_used, rs2_used  in  1  operand actually consumed this cycle
- rs1_data, rs2_data  out  WORD_SIZE  read data
- rs1_busy, rs2_busy  out  1  operand has a pending write
- stall  out  1  (rs1_used & rs1_busy) | (rs2_used & rs2_busy)
- issue_en  in  1  request to mark issue_addr as pending
- issue_addr  in  ADDR_W  destination of issuing instruction
- issue_ready  out  1  issue_addr may be marked this cycle
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  WORD_SIZE  writeback data
- pending_cnt  out  $clog2(NUM_REGS+1)  number of busy registers

## Operation
- Reset (reset_n low, asynchronous): all GPRs = 0, all busy bits = 0, pending_cnt = 0. Outputs follow combinationally: data 0, busy 0, stall 0, issue_ready 1.
- Read: rsN_data = GPR[rsN_addr]. If BYPASS=1 and wr_en and wr_addr==rsN_addr: rsN_data = wr_data, rsN_busy = 0.
- rsN_busy = busy[rsN_addr] (subject to bypass rule above). ZERO_R0=1: address 0 reads 0, busy 0.
- Write: on edge with wr_en, GPR[wr_addr] ← wr_data and busy[wr_addr] cleared. ZERO_R0=1 and wr_addr==0: ignored.
- Issue: issue_ready = !busy[issue_addr] | (wr_en & wr_addr==issue_addr). Accepted = issue_en & issue_ready; sets busy[issue_addr] on the edge. issue_en while not ready is ignored (no state change); the requester must hold and retry. ZERO_R0=1 and issue_addr==0: always ready, never sets busy.
- Simultaneous write and accepted issue to the same address: data written, busy ends set (new producer wins).
- pending_cnt: +1 per accepted issue that sets a clear bit, −1 per write that clears a set bit; both to the same busy register = net 0. Always equals the popcount of busy; never wraps.
- Writes to non-busy registers are legal (busy unaffected, count unchanged).

## Timing
- Reads, busy, stall, issue_ready: combinational, same cycle.
- Write visible on reads the next cycle (same cycle when BYPASS=1).
- Busy set is visible the cycle after an accepted issue; busy clear is visible the same cycle via bypass, and from the next cycle otherwise.
- reset_n assertion mid-operation clears everything immediately. Deassertion is synchronised externally; the first edge after release performs normal updates.

## Structure
- Shared package holds WORD_SIZE default, NUM_REGS default and the address-width function. This replaces the global width/count macros for this block.
- Sub-module gpr_scoreboard: busy vector, issue/clear arbitration, pending_cnt, issue_ready. The top-level wraps it with the storage array and read/bypass muxes.

## Test plan
- Reset then read all regs: with reset_n low mid-run after writes, rs1_data/rs2_data = 0, pending_cnt = 0, stall = 0.
- Write R2←16'hBEEF, read rs1_addr=2 the same cycle: BYPASS=1 gives 16'hBEEF that cycle; BYPASS=0 gives the old value, then 16'hBEEF next cycle.
- Issue R1, then read rs1_addr=1 with rs1_used=1: stall = 1 next cycle. Writeback R1←16'h0042: stall 0 in that cycle (BYPASS=1), data 16'h0042.
- Issue R3 twice without writeback: second issue has issue_ready = 0 and pending_cnt stays 1. Same-cycle write+issue R3: busy stays 1, pending_cnt stays 1.
- Issue R0–R3 on consecutive cycles: pending_cnt = 4. Write all four back: pending_cnt = 0. ZERO_R0=1: R0 issue leaves count at 3, and a write of 16'hFFFF to R0 reads 0.
- Write to non-busy R2 while R1 is busy: pending_cnt unchanged at 1, R2 data updated.

Source files
------------

// File: rtl/gpr_file_sb_pkg.sv
// Shared sizing defaults and width helpers for the GPR file with scoreboard.
package gpr_file_sb_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int NUM_REGS_DEF  = 4;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gpr_file_sb_if.sv
// Decode/writeback bus of the GPR file: two read ports, issue request, writeback, status.
interface gpr_file_sb_if
  import gpr_file_sb_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF
);
  localparam int ADDR_W = addr_width(NUM_REGS);
  localparam int CNT_W  = cnt_width(NUM_REGS);

  logic [ADDR_W-1:0]    rs1_addr;
  logic [ADDR_W-1:0]    rs2_addr;
  logic                 rs1_used;
  logic                 rs2_used;
  logic [WORD_SIZE-1:0] rs1_data;
  logic [WORD_SIZE-1:0] rs2_data;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic                 stall;
  logic                 issue_en;
  logic [ADDR_W-1:0]    issue_addr;
  logic                 issue_ready;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic [CNT_W-1:0]     pending_cnt;

  modport master (
    output rs1_addr, rs2_addr, rs1_used, rs2_used,
    output issue_en, issue_addr, wr_en, wr_addr, wr_data,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall, issue_ready, pending_cnt
  );

  modport slave (
    input  rs1_addr, rs2_addr, rs1_used, rs2_used,
    input  issue_en, issue_addr, wr_en, wr_addr, wr_data,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, stall, issue_ready, pending_cnt
  );

endinterface

// File: rtl/gpr_file_sb_scoreboard.sv
// Busy-bit scoreboard: per-register pending-write flags, issue acceptance and pending count.
module gpr_scoreboard
  import gpr_file_sb_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = addr_width(NUM_REGS),
  parameter int CNT_W    = cnt_width(NUM_REGS),
  parameter int ZERO_R0  = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                issue_ready,
  output logic [CNT_W-1:0]    pending_cnt
);

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                cnt_inc;
  logic                cnt_dec;

  // A writeback to the issuing destination frees it in the same cycle, so the
  // new producer may claim it immediately and its set overrides the clear.
  always_comb begin
    set_vec     = '0;
    clr_vec     = '0;
    issue_ready = !busy[issue_addr] || (wr_en && wr_addr == issue_addr) ||
                  (ZERO_R0 != 0 && issue_addr == '0);
    if (issue_en && issue_ready && !(ZERO_R0 != 0 && issue_addr == '0))
      set_vec[issue_addr] = 1'b1;
    if (wr_en && !(ZERO_R0 != 0 && wr_addr == '0))
      clr_vec[wr_addr] = 1'b1;
    busy_nxt = (busy & ~clr_vec) | set_vec;
    cnt_inc  = |(set_vec & ~busy);
    cnt_dec  = |(clr_vec & busy & ~set_vec);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      case ({cnt_inc, cnt_dec})
        2'b10:   pending_cnt <= pending_cnt + CNT_W'(1);
        2'b01:   pending_cnt <= pending_cnt - CNT_W'(1);
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

endmodule

// File: rtl/gpr_file_sb.sv
// Register file with two combinational read ports, optional write-through bypass and busy scoreboard.
module gpr_file_sb
  import gpr_file_sb_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int ADDR_W    = addr_width(NUM_REGS),
  parameter int BYPASS    = 1,
  parameter int ZERO_R0   = 0
) (
  input logic          clk,
  input logic          reset_n,
  gpr_file_sb_if.slave bus
);

  localparam int CNT_W = cnt_width(NUM_REGS);

  logic [WORD_SIZE-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]  busy;
  logic                 issue_ready;
  logic [CNT_W-1:0]     pending_cnt;
  logic                 wr_ok;
  logic [ADDR_W-1:0]    rd_addr [2];
  logic [WORD_SIZE-1:0] rd_data [2];
  logic                 rd_busy [2];

  gpr_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .ZERO_R0  (ZERO_R0)
  ) u_sb (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue_en    (bus.issue_en),
    .issue_addr  (bus.issue_addr),
    .wr_en       (bus.wr_en),
    .wr_addr     (bus.wr_addr),
    .busy        (busy),
    .issue_ready (issue_ready),
    .pending_cnt (pending_cnt)
  );

  assign wr_ok = bus.wr_en && !(ZERO_R0 != 0 && bus.wr_addr == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign rd_addr[0] = bus.rs1_addr;
  assign rd_addr[1] = bus.rs2_addr;

  // Hardwired R0 takes precedence over the bypass so a write to R0 never leaks out.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]];
      if (ZERO_R0 != 0 && rd_addr[p] == '0) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end else if (BYPASS != 0 && bus.wr_en && bus.wr_addr == rd_addr[p]) begin
        rd_data[p] = bus.wr_data;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign bus.rs1_data    = rd_data[0];
  assign bus.rs2_data    = rd_data[1];
  assign bus.rs1_busy    = rd_busy[0];
  assign bus.rs2_busy    = rd_busy[1];
  assign bus.stall       = (bus.rs1_used & rd_busy[0]) | (bus.rs2_used & rd_busy[1]);
  assign bus.issue_ready = issue_ready;
  assign bus.pending_cnt = pending_cnt;

endmodule
